// File: rtl/dac_spi_transmitter_pkg.sv
// dac_spi_transmitter_pkg: shared defaults and FSM encoding for the SPI DAC transmitter
package dac_spi_transmitter_pkg;
  localparam int DEF_DATA_W = 12;
  localparam int DEF_CLK_DIV = 4;
  localparam logic [3:0] DEF_CFG_NIB = 4'b0111;
  localparam int FRAME_W = 4 + DEF_DATA_W;
  typedef enum logic [1:0] {IDLE, SHIFT, CS_HIGH, LDAC} state_e;
endpackage

// File: rtl/dac_spi_transmitter_if.sv
// dac_spi_transmitter_if: sample handshake, status flags and SPI DAC pins
interface dac_spi_transmitter_if #(parameter int DATA_W = 12);
  logic              sample_valid;
  logic [DATA_W-1:0] sample_data;
  logic              sample_ready;
  logic              busy;
  logic              frame_done;
  logic              overrun;
  logic              dac_cs_n;
  logic              dac_sclk;
  logic              dac_mosi;
  logic              dac_ldac_n;
  modport master (output sample_valid, sample_data,
                  input  sample_ready, busy, frame_done, overrun, dac_cs_n, dac_sclk, dac_mosi, dac_ldac_n);
  modport slave  (input  sample_valid, sample_data,
                  output sample_ready, busy, frame_done, overrun, dac_cs_n, dac_sclk, dac_mosi, dac_ldac_n);
endinterface

// File: rtl/dac_spi_clkgen.sv
// dac_spi_clkgen: CLK_DIV phase counter producing SCLK rise/fall enables
module dac_spi_clkgen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic sclk_rise,
  output logic sclk_fall
);
  localparam int CNT_W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic lvl_q, lvl_d, last;
  // lvl tracks which half-period is running: 0 = low phase, 1 = high phase
  always_comb begin
    last = cnt_q == CNT_LAST;
    cnt_d = (!en || clr || last) ? '0 : cnt_q + 1'b1;
    lvl_d = (!en || clr) ? 1'b0 : lvl_q ^ last;
    sclk_rise = en && last && !lvl_q;
    sclk_fall = en && last && lvl_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q <= '0;
      lvl_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      lvl_q <= lvl_d;
    end
endmodule

// File: rtl/dac_spi_transmitter.sv
// dac_spi_transmitter: frames 12-bit samples as {CFG_NIB,data} and shifts them to an SPI DAC, MSB first.
// Define DAC_SPI_LDAC_EN to add a 2*CLK_DIV ldac_n pulse after each frame.
module dac_spi_transmitter
  import dac_spi_transmitter_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter logic [3:0] CFG_NIB = DEF_CFG_NIB
) (
  input logic clk,
  input logic rst_n,
  dac_spi_transmitter_if.slave bus
);
  localparam int FW = 4 + DATA_W;
  localparam int BIT_W = $clog2(FW);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FW - 1);
`ifdef DAC_SPI_LDAC_EN
  localparam logic LDAC_RST = 1'b1;
`else
  localparam logic LDAC_RST = 1'b0;
`endif
  state_e state_q, state_d;
  logic [FW-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic hold_full_q, hold_full_d, tail_q, tail_d;
  logic cs_n_q, cs_n_d, sclk_q, sclk_d, mosi_q, mosi_d, ldac_n_q, ldac_n_d;
  logic busy_q, busy_d, done_q, done_d, ready_q, ready_d, overrun_q, overrun_d;
  logic sclk_rise, sclk_fall, launch, store;
  assign launch = state_q == IDLE && (bus.sample_valid || hold_full_q);
  assign store = bus.sample_valid && (state_q != IDLE || hold_full_q);
  dac_spi_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (state_q != IDLE),
    .clr       (state_d != state_q),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  // each state restarts the phase counter, so a rise enable marks CLK_DIV cycles in state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = launch ? SHIFT : IDLE;
      SHIFT:   state_d = (sclk_rise && tail_q) ? CS_HIGH : SHIFT;
`ifdef DAC_SPI_LDAC_EN
      CS_HIGH: state_d = sclk_rise ? LDAC : CS_HIGH;
      default: state_d = sclk_fall ? IDLE : LDAC;
`else
      default: state_d = sclk_rise ? IDLE : CS_HIGH;
`endif
    endcase
  end
  always_comb begin
    shreg_d = shreg_q;
    bit_d = bit_q;
    tail_d = tail_q;
    mosi_d = mosi_q;
    sclk_d = sclk_q;
    if (launch) begin
      shreg_d = {CFG_NIB, hold_full_q ? hold_q : bus.sample_data};
      bit_d = '0;
      tail_d = 1'b0;
      mosi_d = CFG_NIB[3];
    end else if (state_q == SHIFT) begin
      if (sclk_rise) sclk_d = !tail_q;
      if (sclk_fall) begin
        sclk_d = 1'b0;
        tail_d = bit_q == LAST_BIT;
        bit_d = tail_d ? bit_q : bit_q + 1'b1;
        shreg_d = tail_d ? shreg_q : shreg_q << 1;
        mosi_d = tail_d ? mosi_q : shreg_q[FW-2];
      end
    end
    cs_n_d = state_d != SHIFT;
    busy_d = state_d != IDLE;
    done_d = state_q == SHIFT && state_d == CS_HIGH;
    hold_d = store ? bus.sample_data : hold_q;
    hold_full_d = store || (hold_full_q && !launch);
    overrun_d = overrun_q || (store && hold_full_q && !launch);
    ready_d = state_d == IDLE && !hold_full_d;
`ifdef DAC_SPI_LDAC_EN
    ldac_n_d = state_d != LDAC;
`else
    ldac_n_d = 1'b0;
`endif
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      shreg_q <= '0;
      hold_q <= '0;
      bit_q <= '0;
      hold_full_q <= 1'b0;
      tail_q <= 1'b0;
      cs_n_q <= 1'b1;
      sclk_q <= 1'b0;
      mosi_q <= 1'b0;
      ldac_n_q <= LDAC_RST;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ready_q <= 1'b1;
      overrun_q <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      hold_q <= hold_d;
      bit_q <= bit_d;
      hold_full_q <= hold_full_d;
      tail_q <= tail_d;
      cs_n_q <= cs_n_d;
      sclk_q <= sclk_d;
      mosi_q <= mosi_d;
      ldac_n_q <= ldac_n_d;
      busy_q <= busy_d;
      done_q <= done_d;
      ready_q <= ready_d;
      overrun_q <= overrun_d;
    end
  assign bus.dac_cs_n = cs_n_q;
  assign bus.dac_sclk = sclk_q;
  assign bus.dac_mosi = mosi_q;
  assign bus.dac_ldac_n = ldac_n_q;
  assign bus.busy = busy_q;
  assign bus.frame_done = done_q;
  assign bus.sample_ready = ready_q;
  assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_dac_spi_transmitter.sv
// tb_dac_spi_transmitter: directed + random samples checked against a timing/queue reference model
module tb_dac_spi_transmitter;
  localparam int D = 4;
`ifdef DAC_SPI_LDAC_EN
  localparam int P = 34 * D + 1 + 2 * D;
`else
  localparam int P = 34 * D + 1;
`endif
  typedef struct {logic [15:0] f; int e;} exp_t;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0, failures = 0;
  int edge_n = 0, free = 0, nfr = 0;
  bit pend = 1'b0, m_ovr = 1'b0;
  logic [11:0] pend_d;
  logic [15:0] last_frame = '0;
  exp_t expq[$];
  dac_spi_transmitter_if #(.DATA_W(12)) bus();
  dac_spi_transmitter #(.DATA_W(12), .CLK_DIV(D)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic pulse(input logic [11:0] d);
    @(posedge clk);
    #1 bus.sample_valid = 1'b1;
    bus.sample_data = d;
    @(posedge clk);
    #1 bus.sample_valid = 1'b0;
  endtask
  task automatic wait_nfr(input int tgt);
    for (int i = 0; i < 4000 && nfr < tgt; i++) @(posedge clk);
    chk("frame_wait", nfr, tgt);
  endtask
  // reference: one frame occupies P edges from its launch; a busy-time sample waits in a single slot
  initial forever begin
    @(posedge clk);
    edge_n++;
    if (!rst_n) begin
      pend = 1'b0;
      free = 0;
      m_ovr = 1'b0;
      expq.delete();
    end else begin
      if (pend && edge_n >= free) begin
        expq.push_back('{f: {4'h7, pend_d}, e: edge_n});
        free = edge_n + P;
        pend = 1'b0;
      end
      if (bus.sample_valid) begin
        if (edge_n >= free) begin
          expq.push_back('{f: {4'h7, bus.sample_data}, e: edge_n});
          free = edge_n + P;
        end else begin
          if (pend) m_ovr = 1'b1;
          pend = 1'b1;
          pend_d = bus.sample_data;
        end
      end
    end
  end
  // SPI monitor sampling on the falling clock edge
  initial begin
    logic p_cs, p_sclk, p_mosi, in_fr, exp_ldac, exp_busy;
    logic [15:0] sh;
    int low, nb, since;
    p_cs = 1'b1; p_sclk = 1'b0; p_mosi = 1'b0; in_fr = 1'b0;
    sh = '0; low = 0; nb = 0; since = 1000;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        p_cs = 1'b1; p_sclk = 1'b0; in_fr = 1'b0; since = 1000;
      end else begin
        if (p_cs && !bus.dac_cs_n) begin
          in_fr = 1'b1; low = 0; nb = 0; sh = '0;
          chk("exp_avail", expq.size() != 0, 1);
          if (expq.size() != 0) chk("cs_fall_edge", edge_n, expq[0].e);
        end
        if (!bus.dac_cs_n) begin
          low++;
          if (!p_sclk && bus.dac_sclk) begin
            chk("mosi_stable", bus.dac_mosi, p_mosi);
            sh = {sh[14:0], bus.dac_mosi};
            nb++;
          end
        end else chk("sclk_idle", bus.dac_sclk, 0);
        chk("frame_done", bus.frame_done, !p_cs && bus.dac_cs_n);
        if (!p_cs && bus.dac_cs_n && in_fr) begin
          chk("nbits", nb, 16);
          chk("cs_low_len", low, 33 * D);
          if (expq.size() != 0) begin
            chk("frame", sh, expq[0].f);
            void'(expq.pop_front());
          end
          last_frame = sh;
          in_fr = 1'b0;
          since = 0;
          nfr++;
        end else if (bus.dac_cs_n) since++;
`ifdef DAC_SPI_LDAC_EN
        exp_ldac = !(bus.dac_cs_n && since >= D && since < 3 * D);
`else
        exp_ldac = 1'b0;
`endif
        chk("ldac_n", bus.dac_ldac_n, exp_ldac);
        exp_busy = edge_n + 1 < free;
        chk("busy", bus.busy, exp_busy);
        chk("ready", bus.sample_ready, !exp_busy && !pend);
        chk("overrun", bus.overrun, m_ovr);
        p_cs = bus.dac_cs_n; p_sclk = bus.dac_sclk; p_mosi = bus.dac_mosi;
      end
    end
  end
  initial begin
    int base;
    logic [11:0] r;
    rst_n = 1'b0;
    bus.sample_valid = 1'b0;
    bus.sample_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cs_n", bus.dac_cs_n, 1);
    chk("rst_sclk", bus.dac_sclk, 0);
    chk("rst_mosi", bus.dac_mosi, 0);
`ifdef DAC_SPI_LDAC_EN
    chk("rst_ldac_n", bus.dac_ldac_n, 1);
`else
    chk("rst_ldac_n", bus.dac_ldac_n, 0);
`endif
    chk("rst_ready", bus.sample_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.frame_done, 0);
    chk("rst_overrun", bus.overrun, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    base = nfr;
    pulse(12'hA5C);
    chk("cs_latency", bus.dac_cs_n, 0);
    wait_nfr(base + 1);
    chk("frame_a5c", last_frame, 16'h7A5C);
    repeat (20) @(posedge clk);
    pulse(12'h000);
    wait_nfr(base + 2);
    chk("frame_000", last_frame, 16'h7000);
    repeat (50) @(posedge clk);
    pulse(12'hFFF);
    wait_nfr(base + 3);
    chk("frame_fff", last_frame, 16'h7FFF);
    repeat (20) @(posedge clk);
    pulse(12'(($urandom)));
    repeat (9) @(posedge clk);
    pulse(12'h123);
    wait_nfr(base + 5);
    chk("frame_123", last_frame, 16'h7123);
    chk("no_overrun", bus.overrun, 0);
    repeat (20) @(posedge clk);
    pulse(12'(($urandom)));
    pulse(12'h111);
    repeat (10) @(posedge clk);
    pulse(12'h222);
    repeat (10) @(posedge clk);
    pulse(12'h333);
    chk("overrun_set", bus.overrun, 1);
    wait_nfr(base + 7);
    chk("frame_333", last_frame, 16'h7333);
    repeat (30) @(posedge clk);
    chk("overrun_sticky", bus.overrun, 1);
    pulse(12'(($urandom)));
    repeat (1 + 7 * 2 * D) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_cs_n", bus.dac_cs_n, 1);
    chk("midrst_sclk", bus.dac_sclk, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_overrun", bus.overrun, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    base = nfr;
    r = 12'($urandom);
    pulse(r);
    wait_nfr(base + 1);
    chk("frame_after_rst", last_frame, {4'h7, r});
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 250)) @(posedge clk);
      pulse(12'($urandom));
    end
    repeat (400) @(posedge clk);
    chk("queue_drained", expq.size(), 0);
    chk("idle_busy", bus.busy, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
